// File: rtl/mux_16bit_6i_1o_pkg.sv
// -----------------------------------------------------------------------------
// mux_16bit_6i_1o_pkg
// Shared constants for the 6-input word selector: default data width, the
// select encoding of operands a..f and the highest legal select code.
// Optional feature macro used by the block: MUX_OUTREG_EN (registered output).
// -----------------------------------------------------------------------------
package mux_16bit_6i_1o_pkg;

   localparam int WIDTH_DEFAULT = 16;

   localparam logic [2:0] SEL_A   = 3'd0;
   localparam logic [2:0] SEL_B   = 3'd1;
   localparam logic [2:0] SEL_C   = 3'd2;
   localparam logic [2:0] SEL_D   = 3'd3;
   localparam logic [2:0] SEL_E   = 3'd4;
   localparam logic [2:0] SEL_F   = 3'd5;
   localparam logic [2:0] SEL_MAX = 3'd5;

   // True when the select code addresses one of the six operands.
   function automatic logic sel_legal(input logic [2:0] sel);
      return (sel <= SEL_MAX);
   endfunction

endpackage

// File: rtl/mux_16bit_6i_1o_if.sv
// -----------------------------------------------------------------------------
// mux_16bit_6i_1o_if
// Operand/result bundle of the word selector.
//   s            : 3-bit select (0..5 legal, 6/7 illegal)
//   a..f         : WIDTH-bit operands 0..5
//   r            : selected operand
//   sel_err      : current select is illegal
//   sel_err_seen : sticky illegal-select flag
// Modports: master drives s/a..f and observes results; slave is the selector.
// -----------------------------------------------------------------------------
interface mux_16bit_6i_1o_if
   import mux_16bit_6i_1o_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);
   logic [2:0]       s;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] r;
   logic             sel_err;
   logic             sel_err_seen;

   modport master (
      output s, a, b, c, d, e, f,
      input  r, sel_err, sel_err_seen
   );

   modport slave (
      input  s, a, b, c, d, e, f,
      output r, sel_err, sel_err_seen
   );
endinterface

// File: rtl/mux_16bit_6i_1o_out_stage.sv
// -----------------------------------------------------------------------------
// mux_out_stage
// Optional output register of the word selector (used only when MUX_OUTREG_EN
// is defined). Captures the selected word and illegal-select flag each rising
// clock edge; synchronous active-high reset loads zeros.
//   clk, reset      : clock, synchronous reset
//   d_data, d_err   : combinational selector result and illegal flag
//   q_data, q_err   : registered copies, 1-cycle latency
// -----------------------------------------------------------------------------
module mux_out_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_data,
   input  logic             d_err,
   output logic [WIDTH-1:0] q_data,
   output logic             q_err
);

   logic [WIDTH-1:0] data_r;
   logic             err_r;

   // Output pipeline register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_r <= {WIDTH{1'b0}};
         err_r  <= 1'b0;
      end else begin
         data_r <= d_data;
         err_r  <= d_err;
      end
   end

   assign q_data = data_r;
   assign q_err  = err_r;

endmodule

// File: rtl/mux_16bit_6i_1o.sv
// -----------------------------------------------------------------------------
// mux_16bit_6i_1o
// 6-input word selector feeding the register-file / ALU operand paths, with
// select-range checking and a sticky illegal-select flag.
//   clk    : system clock
//   reset  : synchronous active-high reset (clears sel_err_seen)
//   bus    : slave side of mux_16bit_6i_1o_if (s, a..f in; r, sel_err,
//            sel_err_seen out)
// Macro MUX_OUTREG_EN: when defined, r and sel_err are registered (1-cycle
// latency, reset to 0); otherwise they are purely combinational.
// -----------------------------------------------------------------------------
module mux_16bit_6i_1o
   import mux_16bit_6i_1o_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   mux_16bit_6i_1o_if.slave   bus
);

   logic [WIDTH-1:0] sel_data_s;
   logic             illegal_s;
   logic             seen_r;

   // Operand selector; illegal codes 6/7 produce an all-zero word.
   always_comb begin
      sel_data_s = {WIDTH{1'b0}};
      case (bus.s)
         SEL_A:   sel_data_s = bus.a;
         SEL_B:   sel_data_s = bus.b;
         SEL_C:   sel_data_s = bus.c;
         SEL_D:   sel_data_s = bus.d;
         SEL_E:   sel_data_s = bus.e;
         SEL_F:   sel_data_s = bus.f;
         default: sel_data_s = {WIDTH{1'b0}};
      endcase
   end

   assign illegal_s = ~sel_legal(bus.s);

   // Sticky illegal-select flag; reset wins over a simultaneous illegal select.
   always_ff @(posedge clk) begin
      if (reset) begin
         seen_r <= 1'b0;
      end else if (illegal_s) begin
         seen_r <= 1'b1;
      end else begin
         seen_r <= seen_r;
      end
   end

   assign bus.sel_err_seen = seen_r;

`ifdef MUX_OUTREG_EN
   logic [WIDTH-1:0] out_data_s;
   logic             out_err_s;

   mux_out_stage #(
      .WIDTH (WIDTH)
   ) u_out_stage (
      .clk    (clk),
      .reset  (reset),
      .d_data (sel_data_s),
      .d_err  (illegal_s),
      .q_data (out_data_s),
      .q_err  (out_err_s)
   );

   assign bus.r       = out_data_s;
   assign bus.sel_err = out_err_s;
`else
   assign bus.r       = sel_data_s;
   assign bus.sel_err = illegal_s;
`endif

endmodule

// File: tb/tb_mux_16bit_6i_1o.sv
// -----------------------------------------------------------------------------
// tb_mux_16bit_6i_1o
// Directed and randomized self-checking bench for mux_16bit_6i_1o. Works for
// both the default build and the MUX_OUTREG_EN build.
// -----------------------------------------------------------------------------
module tb_mux_16bit_6i_1o;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mux_16bit_6i_1o_if #(.WIDTH(16)) bus ();

   mux_16bit_6i_1o #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the operands as an array indexed by the select value.
   function automatic logic [15:0] ref_r(input logic [2:0] sel);
      logic [15:0] ops [6];
      ops = '{bus.a, bus.b, bus.c, bus.d, bus.e, bus.f};
      if (sel < 3'd6) return ops[sel];
      else            return 16'h0000;
   endfunction

   function automatic logic ref_err(input logic [2:0] sel);
      return (sel == 3'd6) || (sel == 3'd7);
   endfunction

   // Clocked expectations: sticky flag and (registered build) delayed outputs.
   logic        seen_m;
   logic [15:0] exp_r_q;
   logic        exp_err_q;
   always @(posedge clk) begin
      if (reset) begin
         seen_m    = 1'b0;
         exp_r_q   = 16'h0000;
         exp_err_q = 1'b0;
      end else begin
         if (ref_err(bus.s)) seen_m = 1'b1;
         exp_r_q   = ref_r(bus.s);
         exp_err_q = ref_err(bus.s);
      end
   end

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare all three outputs against the reference model.
   task automatic check_model(input string tag);
      logic [15:0] er;
      logic        ee;
`ifdef MUX_OUTREG_EN
      er = exp_r_q;
      ee = exp_err_q;
`else
      er = ref_r(bus.s);
      ee = ref_err(bus.s);
`endif
      check_val({tag, ".r"}, bus.r, er);
      check_val({tag, ".sel_err"}, {15'd0, bus.sel_err}, {15'd0, ee});
      check_val({tag, ".seen"}, {15'd0, bus.sel_err_seen}, {15'd0, seen_m});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.s  = 3'd0;
      bus.a  = 16'd8;   bus.b = 16'd16;  bus.c = 16'd32;
      bus.d  = 16'd64;  bus.e = 16'd128; bus.f = 16'd256;
      seen_m = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_val("reset_seen", {15'd0, bus.sel_err_seen}, 16'd0);
      check_model("reset");
      reset = 1'b0;

      // Sweep legal selects, 100 ns each
      for (int i = 0; i < 6; i++) begin
         bus.s = i[2:0];
         #100;
         check_val("sweep_r", bus.r, 16'd8 << i);
         check_val("sweep_err", {15'd0, bus.sel_err}, 16'd0);
         check_val("sweep_seen", {15'd0, bus.sel_err_seen}, 16'd0);
      end

      // Operand change on the selected input, no clock edge in between
      @(negedge clk);
      bus.s = 3'd2;
      @(negedge clk);
      bus.c = 16'hBEEF;
      #2;
`ifndef MUX_OUTREG_EN
      check_val("follow_c", bus.r, 16'hBEEF);
`endif
      check_model("follow_c_model");

      // Illegal selects
      @(negedge clk);
      bus.s = 3'd6;
      #2;
      check_model("sel6_mid");
      @(negedge clk);
      check_val("sel6_r", bus.r, 16'h0000);
      check_val("sel6_err", {15'd0, bus.sel_err}, 16'd1);
      check_val("sel6_seen", {15'd0, bus.sel_err_seen}, 16'd1);
      bus.s = 3'd7;
      @(negedge clk);
      check_val("sel7_r", bus.r, 16'h0000);
      check_val("sel7_err", {15'd0, bus.sel_err}, 16'd1);
      bus.s = 3'd1;
      @(negedge clk);
      check_val("back1_r", bus.r, 16'd16);
      check_val("back1_err", {15'd0, bus.sel_err}, 16'd0);
      check_val("back1_seen", {15'd0, bus.sel_err_seen}, 16'd1);

      // Reset has priority over an illegal select
      bus.s = 3'd7;
      reset = 1'b1;
      @(negedge clk);
      check_val("rst_pri_seen", {15'd0, bus.sel_err_seen}, 16'd0);
      check_model("rst_pri");
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_rel_seen", {15'd0, bus.sel_err_seen}, 16'd1);

      // Leakage: only the selected operand is 0x0001
      for (int i = 0; i < 6; i++) begin
         bus.a = (i == 0) ? 16'h0001 : 16'hFFFF;
         bus.b = (i == 1) ? 16'h0001 : 16'hFFFF;
         bus.c = (i == 2) ? 16'h0001 : 16'hFFFF;
         bus.d = (i == 3) ? 16'h0001 : 16'hFFFF;
         bus.e = (i == 4) ? 16'h0001 : 16'hFFFF;
         bus.f = (i == 5) ? 16'h0001 : 16'hFFFF;
         bus.s = i[2:0];
         @(negedge clk);
         check_val("leak_r", bus.r, 16'h0001);
      end

`ifdef MUX_OUTREG_EN
      // Registered output: one-cycle latency, reset clears r and sel_err
      bus.a = 16'd8; bus.e = 16'd128; bus.s = 3'd0;
      @(negedge clk);
      bus.s = 3'd4;
      #2;
      check_val("reg_hold", bus.r, 16'd8);
      @(negedge clk);
      check_val("reg_upd", bus.r, 16'd128);
      bus.s = 3'd6;
      reset = 1'b1;
      @(negedge clk);
      check_val("reg_rst_r", bus.r, 16'h0000);
      check_val("reg_rst_err", {15'd0, bus.sel_err}, 16'd0);
      reset = 1'b0;
`endif

      // Randomized traffic against the reference model
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         reset = ($urandom_range(15) == 0);
         bus.s = 3'($urandom_range(7));
         bus.a = 16'($urandom); bus.b = 16'($urandom); bus.c = 16'($urandom);
         bus.d = 16'($urandom); bus.e = 16'($urandom); bus.f = 16'($urandom);
         #2;
         check_model("rand_mid");
      end
      @(negedge clk);
      check_model("rand_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
